backlight_spi_rx: RTL and testbench

//  Receiving end of the backlight serial link: deserializes the 10-bit words carried on HSYNC/data/enable,

---
 rtl/backlight_pkg.sv | 34 +++
 rtl/backlight_spi_rx_if.sv | 41 ++++
 rtl/bl_sync_edge.sv | 38 +++
 rtl/backlight_spi_rx.sv | 192 +++++++++++++++++++
 tb/tb_backlight_spi_rx.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/backlight_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : backlight_pkg
//  Description : Shared constants and rx FSM encodings for the backlight
//                serial link (receiver and transmitter).
//  Revision    : 1.0 - initial release
// ============================================================================
package backlight_pkg;

    localparam int WORD_BITS    = 10;
    localparam int CH_PER_FRAME = 16;
    localparam int NUM_SCAN     = 3;
    localparam int CH_W         = $clog2(CH_PER_FRAME);
    localparam int SCAN_W       = 2;
    localparam int BIT_CNT_W    = $clog2(WORD_BITS + 1);

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_SHIFT    = 2'd1,
        RX_WAIT_LOW = 2'd2
    } rx_state_t;

    // Bank index of a one-hot scan strobe; caller guarantees one-hot input.
    function automatic logic [SCAN_W-1:0] scan_index(input logic [NUM_SCAN-1:0] oh);
        logic [SCAN_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_SCAN; i++) begin
            if (oh[i]) idx = SCAN_W'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/backlight_spi_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : backlight_spi_rx_if
//  Description : Serial link, status and bank read-port bundle of the
//                backlight receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface backlight_spi_rx_if;
    import backlight_pkg::*;

    logic                 hsync;
    logic                 sdin;
    logic                 sen;
    logic [NUM_SCAN-1:0]  qscan;
    logic [WORD_BITS-1:0] word_data;
    logic [CH_W-1:0]      word_ch;
    logic                 word_valid;
    logic                 frame_ready;
    logic                 commit;
    logic [SCAN_W-1:0]    commit_scan;
    logic                 word_err;
    logic                 frame_err;
    logic                 scan_err;
    logic [SCAN_W-1:0]    rd_scan;
    logic [CH_W-1:0]      rd_ch;
    logic [WORD_BITS-1:0] rd_data;

    modport master (
        output hsync, sdin, sen, qscan, rd_scan, rd_ch,
        input  word_data, word_ch, word_valid, frame_ready, commit, commit_scan,
        input  word_err, frame_err, scan_err, rd_data
    );

    modport slave (
        input  hsync, sdin, sen, qscan, rd_scan, rd_ch,
        output word_data, word_ch, word_valid, frame_ready, commit, commit_scan,
        output word_err, frame_err, scan_err, rd_data
    );

endinterface
`default_nettype wire

// File: rtl/bl_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : bl_sync_edge
//  Description : 2-FF synchronizer with one extra history stage for edge
//                detection, width-parameterized.
//  Revision    : 1.0 - initial release
// ============================================================================
module bl_sync_edge #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_d
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign q   = r_sync;
    assign q_d = r_prev;

endmodule
`default_nettype wire

// File: rtl/backlight_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : backlight_spi_rx
//  Description : Backlight serial receiver: deserializes 10-bit words into a
//                16-entry shadow frame and commits it to the scan-line bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module backlight_spi_rx
    import backlight_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic               clock,
    input  logic               reset,
    backlight_spi_rx_if.slave  bus
);

    localparam int              c_TMR_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(IDLE_TIMEOUT - 1);

    logic [2:0]          w_ser_q, w_ser_qd;
    logic [NUM_SCAN-1:0] w_qscan, w_qscan_d;

    bl_sync_edge #(.WIDTH(3)) u_sync_ser (
        .clock (clock),
        .reset (reset),
        .d     ({bus.hsync, bus.sen, bus.sdin}),
        .q     (w_ser_q),
        .q_d   (w_ser_qd)
    );

    bl_sync_edge #(.WIDTH(NUM_SCAN)) u_sync_qscan (
        .clock (clock),
        .reset (reset),
        .d     (bus.qscan),
        .q     (w_qscan),
        .q_d   (w_qscan_d)
    );

    logic w_bit_evt, w_sen, w_sdin;
    assign w_bit_evt = w_ser_q[2] & ~w_ser_qd[2];
    assign w_sen     = w_ser_q[1];
    assign w_sdin    = w_ser_q[0];
    wire   w_unused_ok = &{1'b0, w_ser_qd[1:0]};

    logic              w_qscan_edge, w_qscan_onehot;
    logic [SCAN_W-1:0] w_scan_idx;
    assign w_qscan_edge   = (w_qscan_d == '0) && (w_qscan != '0);
    assign w_qscan_onehot = $onehot(w_qscan);
    assign w_scan_idx     = scan_index(w_qscan);

    rx_state_t             r_state, w_state_nxt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [WORD_BITS-1:0]  r_shift;
    logic [CH_W-1:0]       r_ch_cnt;
    logic                  r_frame_ready;
    logic [c_TMR_W-1:0]    r_timer;
    logic [WORD_BITS-1:0]  r_shadow [CH_PER_FRAME];
    logic [WORD_BITS-1:0]  r_bank   [NUM_SCAN][CH_PER_FRAME];

    logic [WORD_BITS-1:0]  r_word_data, r_rd_data;
    logic [CH_W-1:0]       r_word_ch;
    logic [SCAN_W-1:0]     r_commit_scan;
    logic                  r_word_valid, r_commit, r_word_err, r_frame_err, r_scan_err;

    logic w_accept, w_word_err, w_shift_en, w_bit_clr;
    logic w_idle_run, w_timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= RX_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_word_err  = 1'b0;
        w_shift_en  = 1'b0;
        w_bit_clr   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_sen) begin
                    w_state_nxt = RX_SHIFT;
                    w_bit_clr   = 1'b1;
                end
            end
            RX_SHIFT: begin
                if (r_bit_cnt == BIT_CNT_W'(WORD_BITS)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RX_WAIT_LOW;
                end else if (!w_sen) begin
                    w_word_err  = (r_bit_cnt != '0);
                    w_state_nxt = RX_IDLE;
                end else if (w_bit_evt) begin
                    w_shift_en  = 1'b1;
                end
            end
            RX_WAIT_LOW: begin
                if (!w_sen) w_state_nxt = RX_IDLE;
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    // A partial frame left idle too long is abandoned; the shadow keeps its data.
    assign w_idle_run = (r_state == RX_IDLE) && !w_sen && (r_ch_cnt != '0);
    assign w_timeout  = w_idle_run && (r_timer == c_TMR_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_ch_cnt      <= '0;
            r_frame_ready <= 1'b0;
            r_timer       <= '0;
            r_word_data   <= '0;
            r_word_ch     <= '0;
            r_word_valid  <= 1'b0;
            r_word_err    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_scan_err    <= 1'b0;
            r_commit      <= 1'b0;
            r_commit_scan <= '0;
            r_rd_data     <= '0;
            for (int c = 0; c < CH_PER_FRAME; c++) r_shadow[c] <= '0;
            for (int s = 0; s < NUM_SCAN; s++)
                for (int c = 0; c < CH_PER_FRAME; c++) r_bank[s][c] <= '0;
        end else begin
            r_word_valid <= 1'b0;
            r_word_err   <= w_word_err;
            r_frame_err  <= 1'b0;
            r_scan_err   <= 1'b0;
            r_commit     <= 1'b0;

            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {r_shift[WORD_BITS-2:0], w_sdin};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (!w_idle_run || w_timeout) r_timer <= '0;
            else                          r_timer <= r_timer + 1'b1;

            if (w_accept) begin
                if (r_frame_ready) begin
                    r_frame_err <= 1'b1;
                end else begin
                    r_word_valid       <= 1'b1;
                    r_word_data        <= r_shift;
                    r_word_ch          <= r_ch_cnt;
                    r_shadow[r_ch_cnt] <= r_shift;
                    r_ch_cnt           <= r_ch_cnt + 1'b1;
                    if (r_ch_cnt == CH_W'(CH_PER_FRAME - 1)) r_frame_ready <= 1'b1;
                end
            end else if (w_timeout) begin
                r_frame_err <= 1'b1;
                r_ch_cnt    <= '0;
            end

            // Commit samples the pre-accept frame_ready, so a same-cycle 16th word waits.
            if (w_qscan_edge) begin
                if (!w_qscan_onehot) begin
                    r_scan_err <= 1'b1;
                end else if (r_frame_ready) begin
                    for (int s = 0; s < NUM_SCAN; s++) begin
                        if (SCAN_W'(s) == w_scan_idx) r_bank[s] <= r_shadow;
                    end
                    r_commit      <= 1'b1;
                    r_commit_scan <= w_scan_idx;
                    r_frame_ready <= 1'b0;
                end
            end

            if (bus.rd_scan < SCAN_W'(NUM_SCAN)) r_rd_data <= r_bank[bus.rd_scan][bus.rd_ch];
            else                                 r_rd_data <= '0;
        end
    end

    assign bus.word_data   = r_word_data;
    assign bus.word_ch     = r_word_ch;
    assign bus.word_valid  = r_word_valid;
    assign bus.frame_ready = r_frame_ready;
    assign bus.commit      = r_commit;
    assign bus.commit_scan = r_commit_scan;
    assign bus.word_err    = r_word_err;
    assign bus.frame_err   = r_frame_err;
    assign bus.scan_err    = r_scan_err;
    assign bus.rd_data     = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_backlight_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_backlight_spi_rx
//  Description : Scoreboard bench for backlight_spi_rx with directed frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_backlight_spi_rx;

    localparam int K_WORD   = 0;
    localparam int K_WERR   = 1;
    localparam int K_FERR   = 2;
    localparam int K_COMMIT = 3;
    localparam int K_SERR   = 4;
    localparam int K_READ   = 5;

    typedef struct {
        int         kind;
        logic [9:0] data;
        logic [3:0] idx;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rd_chk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    backlight_spi_rx_if bus ();

    backlight_spi_rx #(.IDLE_TIMEOUT(4096)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic string kname(input int k);
        case (k)
            K_WORD:   return "word_valid";
            K_WERR:   return "word_err";
            K_FERR:   return "frame_err";
            K_COMMIT: return "commit";
            K_SERR:   return "scan_err";
            K_READ:   return "rd_data";
            default:  return "none";
        endcase
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_evt(input int k, input logic [9:0] d, input logic [3:0] i);
        exp_t e;
        e.kind = k; e.data = d; e.idx = i;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int k, input logic [9:0] d, input logic [3:0] i);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected %s: data=%h idx=%0d, nothing expected", kname(k), d, i);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data !== d || e.idx !== i) begin
                n_bad++;
                $display("FAIL %s: got %s data=%h idx=%0d, expected %s data=%h idx=%0d",
                         kname(e.kind), kname(k), d, i, kname(e.kind), e.data, e.idx);
            end
        end
    endtask

    // Monitor: every output event pops the oldest expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.word_valid) pop_cmp(K_WORD, bus.word_data, bus.word_ch);
            if (bus.word_err)   pop_cmp(K_WERR, 10'h0, 4'h0);
            if (bus.frame_err)  pop_cmp(K_FERR, 10'h0, 4'h0);
            if (bus.commit)     pop_cmp(K_COMMIT, 10'h0, {2'b00, bus.commit_scan});
            if (bus.scan_err)   pop_cmp(K_SERR, 10'h0, 4'h0);
            if (rd_chk)         pop_cmp(K_READ, bus.rd_data, 4'h0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [9:0] w, input int nbits);
        bus.sen = 1'b1;
        tick(2);
        for (int i = 0; i < nbits; i++) begin
            bus.sdin  = w[9-i];
            bus.hsync = 1'b0;
            tick(2);
            bus.hsync = 1'b1;
            tick(3);
        end
        tick(3);
        bus.sen   = 1'b0;
        bus.hsync = 1'b0;
        bus.sdin  = 1'b0;
        tick(5);
    endtask

    task automatic send_word(input logic [9:0] w, input logic [3:0] ch);
        expect_evt(K_WORD, w, ch);
        send_bits(w, 10);
    endtask

    task automatic strobe(input logic [2:0] qs);
        bus.qscan = qs;
        tick(4);
        bus.qscan = 3'b000;
        tick(4);
    endtask

    task automatic rd_expect(input logic [1:0] s, input logic [3:0] c, input logic [9:0] req);
        bus.rd_scan = s;
        bus.rd_ch   = c;
        tick(1);
        expect_evt(K_READ, req, 4'h0);
        rd_chk = 1'b1;
        tick(1);
        rd_chk = 1'b0;
    endtask

    initial begin
        bus.hsync = 1'b0; bus.sdin = 1'b0; bus.sen = 1'b0; bus.qscan = 3'b000;
        bus.rd_scan = 2'd0; bus.rd_ch = 4'd0;
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("reset word_data", bus.word_data, 10'h0);
        chk("reset word_ch", {6'h0, bus.word_ch}, 10'h0);
        chk("reset frame_ready", {9'h0, bus.frame_ready}, 10'h0);
        chk("reset commit_scan", {8'h0, bus.commit_scan}, 10'h0);
        chk("reset rd_data", bus.rd_data, 10'h0);

        // Frame A: 0..15, commit to bank 0
        for (int i = 0; i < 16; i++) send_word(10'(i), 4'(i));
        chk("frame_ready after 16 words", {9'h0, bus.frame_ready}, 10'h1);
        expect_evt(K_COMMIT, 10'h0, 4'd0);
        strobe(3'b001);
        chk("frame_ready after commit", {9'h0, bus.frame_ready}, 10'h0);
        rd_expect(2'd0, 4'd5, 10'h005);

        // Frame B: 0x3FF-x, commit to bank 2
        for (int i = 0; i < 16; i++) send_word(10'(10'h3FF - i), 4'(i));
        expect_evt(K_COMMIT, 10'h0, 4'd2);
        strobe(3'b100);
        rd_expect(2'd2, 4'd0, 10'h3FF);
        rd_expect(2'd2, 4'd15, 10'h3F0);
        rd_expect(2'd0, 4'd5, 10'h005);
        rd_expect(2'd3, 4'd0, 10'h000);

        // Partial word keeps the channel, then idle timeout after 5 words
        send_word(10'h011, 4'd0);
        send_word(10'h022, 4'd1);
        expect_evt(K_WERR, 10'h0, 4'h0);
        send_bits(10'h155, 6);
        send_word(10'h033, 4'd2);
        send_word(10'h044, 4'd3);
        send_word(10'h055, 4'd4);
        expect_evt(K_FERR, 10'h0, 4'h0);
        tick(4200);

        // Frame C from ch 0, 17th word overflows and is dropped
        for (int i = 0; i < 16; i++) send_word(10'(10'h100 + i), 4'(i));
        expect_evt(K_FERR, 10'h0, 4'h0);
        send_bits(10'h3AB, 10);
        expect_evt(K_COMMIT, 10'h0, 4'd0);
        strobe(3'b001);
        rd_expect(2'd0, 4'd0, 10'h100);
        rd_expect(2'd0, 4'd15, 10'h10F);

        // Frame D: non-one-hot strobe rejected, then bank 1
        for (int i = 0; i < 16; i++) send_word(10'(10'h200 + i), 4'(i));
        expect_evt(K_SERR, 10'h0, 4'h0);
        strobe(3'b011);
        chk("frame_ready kept after scan_err", {9'h0, bus.frame_ready}, 10'h1);
        expect_evt(K_COMMIT, 10'h0, 4'd1);
        strobe(3'b010);
        rd_expect(2'd1, 4'd3, 10'h203);
        rd_expect(2'd2, 4'd7, 10'h3F8);

        // Reset mid-word clears everything
        bus.sen = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            bus.sdin = 1'b1; bus.hsync = 1'b0; tick(2); bus.hsync = 1'b1; tick(3);
        end
        reset = 1'b1;
        bus.sen = 1'b0; bus.hsync = 1'b0; bus.sdin = 1'b0;
        tick(3);
        chk("mid-reset word_data", bus.word_data, 10'h0);
        chk("mid-reset frame_ready", {9'h0, bus.frame_ready}, 10'h0);
        chk("mid-reset rd_data", bus.rd_data, 10'h0);
        reset = 1'b0;
        tick(3);
        rd_expect(2'd0, 4'd5, 10'h000);
        rd_expect(2'd1, 4'd3, 10'h000);
        rd_expect(2'd2, 4'd0, 10'h000);
        send_word(10'h2C5, 4'd0);
        tick(10);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending expectations: got %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
